alu_mc: RTL and testbench

Parametrised multi-cycle successor to the datapath ALU. It executes the existing ADD/SUB/AND/ORR operations with compatible encodings, and adds EOR, LSL, LSR and an iterative shift-add MUL. Results and NZCV flags are registered behind a start/busy/done handshake. It sits in the execute stage; the controller stalls while `busy` is high.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 66 ++++++
 rtl/alu_mc.sv | 90 +++++++++
 tb/tb_alu_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op, flag and state definitions for the multi-cycle ALU
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ops (ADD..LSR) with NZCV flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] lsl_ext;
  logic [WIDTH:0] lsr_ext;
  logic           c;
  logic           v;

  assign sh  = b[SHW-1:0];
  assign sum = (op == OP_SUB) ? ({1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1))
                              : ({1'b0, a} + {1'b0, b});

  // One extra bit on each shift catches the last bit shifted out; sh=0 leaves it 0.
  assign lsl_ext = {1'b0, a} << sh;
  assign lsr_ext = {a, 1'b0} >> sh;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_EOR: result = a ^ b;
      OP_LSL: begin
        result = lsl_ext[WIDTH-1:0];
        c      = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        result = lsr_ext[WIDTH:1];
        c      = lsr_ext[0];
      end
      default: ;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle ops plus iterative shift-add multiply
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  alu_op_t          op_e;

  assign op_e = alu_op_t'(op);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_e),
    .a      (a),
    .b      (b),
    .result (core_result),
    .flags  (core_flags)
  );

  assign acc_next = acc + (mb[0] ? ma : '0);
  assign busy     = (state == MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_e == OP_MUL) begin
              ma    <= a;
              mb    <= b;
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              result <= core_result;
              flags  <= core_flags;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          // start is deliberately not looked at here: no queuing while busy.
          acc <= acc_next;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            result <= acc_next;
            flags  <= {acc_next[WIDTH-1], (acc_next == '0), 1'b0, 1'b0};
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  op32 = 3'b000, op8 = 3'b000;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, busy8, done8;
  logic [31:0] result32;
  logic [7:0]  result8;
  logic [3:0]  flags32, flags8;

  exp_t q32[$];
  exp_t q8[$];
  int   tests = 0;
  int   failures = 0;
  bit   busy_seen = 1'b0;
  int   done_cnt32 = 0;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32), .flags(flags32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .flags(flags8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (busy32) busy_seen = 1'b1;
    if (done32) begin
      done_cnt32++;
      if (q32.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_done32: result 0x%0h flags %b with empty scoreboard", result32, flags32);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("result32", result32, e.r);
        check("flags32", {28'd0, flags32}, {28'd0, e.f});
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_done8: result 0x%0h flags %b with empty scoreboard", result8, flags8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("result8", {24'd0, result8}, e.r);
        check("flags8", {28'd0, flags8}, {28'd0, e.f});
      end
    end
  end

  task automatic issue32(input logic [2:0] op, input logic [31:0] x, y, er, input logic [3:0] ef);
    q32.push_back('{r: er, f: ef});
    op32 = op; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] x, y, er, input logic [3:0] ef);
    q8.push_back('{r: {24'd0, er}, f: ef});
    op8 = op; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Launch a multiply, optionally spamming ADD starts while busy; returns busy length.
  task automatic mul32(input logic [31:0] x, y, er, input logic [3:0] ef, input bit spam, output int nbusy);
    q32.push_back('{r: er, f: ef});
    op32 = OP_MUL; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    nbusy = 0;
    while (busy32 && nbusy < 100) begin
      if (spam) begin
        start32 = 1'b1; op32 = OP_ADD; a32 = $urandom; b32 = $urandom;
      end
      @(posedge clk); #1;
      nbusy++;
    end
    start32 = 1'b0;
  endtask

  initial begin
    int nb;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy32}, 32'd0);
    check("reset_done", {31'd0, done32}, 32'd0);
    check("reset_result", result32, 32'd0);
    check("reset_flags", {28'd0, flags32}, 32'd0);
    reset = 1'b0;

    // Back-to-back single-cycle ops, one per clock.
    issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    issue32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    issue32(OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
    issue32(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000);
    issue32(OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
    issue32(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
    issue32(OP_ORR, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000);
    issue32(OP_EOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 4'b0100);
    issue32(OP_LSR, 32'h8000_0001, 32'h0000_0001, 32'h4000_0000, 4'b0010);
    issue32(OP_LSR, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000);
    issue32(OP_LSL, 32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 4'b0110);
    issue32(OP_LSL, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 4'b1000);
    start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_never_single_cycle", {31'd0, busy_seen}, 32'd0);

    // Multiply while hammering start, then ADD accepted in the done cycle.
    mul32(32'd7, 32'd6, 32'd42, 4'b0000, 1'b1, nb);
    check("mul_busy_len", nb, 32'd32);
    issue32(OP_ADD, 32'd1, 32'd1, 32'd2, 4'b0000);
    start32 = 1'b0;
    @(posedge clk); #1;
    check("done_one_pulse", {31'd0, done32}, 32'd0);

    mul32(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0100, 1'b0, nb);
    check("mul_busy_len2", nb, 32'd32);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-multiply: everything clears and no done follows.
    op32 = OP_MUL; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy32}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy32}, 32'd0);
    check("abort_done", {31'd0, done32}, 32'd0);
    check("abort_result", result32, 32'd0);
    check("abort_flags", {28'd0, flags32}, 32'd0);
    done_cnt32 = 0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt32, 32'd0);

    // Narrow instance.
    issue8(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001);
    issue8(OP_LSL, 8'h81, 8'h09, 8'h02, 4'b0010);
    q8.push_back('{r: 32'h0000_0001, f: 4'b0000});
    op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    nb = 0;
    while (busy8 && nb < 100) begin
      @(posedge clk); #1;
      nb++;
    end
    check("mul8_busy_len", nb, 32'd8);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard32_drained", q32.size(), 32'd0);
    check("scoreboard8_drained", q8.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
